// File: rtl/bincnt_seq.sv
// bincnt_seq: multi-cycle popcount, CW bits per clock, with a saturating running total.
// Words are taken over a valid/ready input and results returned over a valid/ready output.
module bincnt_seq #(
    parameter int W = 16,
    parameter int CW = 4,
    parameter int AW = 16,
    localparam int OW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_acc,
    input  logic          clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_cnt,
    output logic [AW-1:0] out_total,
    output logic          out_ovf
);
    localparam int N = W / CW;
    localparam int SW = N > 1 ? $clog2(N) : 1;

    generate
        if (W % CW != 0) begin : g_bad_cfg
            $error("bincnt_seq: W must be a multiple of CW");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  shift;
    logic [OW-1:0] part, chunk_cnt, cnt_nxt;
    logic [SW-1:0] step;
    logic          acc_q, last;
    logic [AW:0]   sum;

    assign last = state == COUNT && step == SW'(N - 1);
    assign cnt_nxt = part + chunk_cnt;
    // clr takes precedence over the old total, so a coinciding accumulate starts from zero
    assign sum = {1'b0, clr ? {AW{1'b0}} : out_total} + {{(AW + 1 - OW){1'b0}}, cnt_nxt};

    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CW; i++) chunk_cnt = chunk_cnt + OW'(shift[i]);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_nxt = COUNT;
            end
            COUNT: if (last) state_nxt = DONE;
            DONE: begin
                out_valid = rst_n;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_cnt   <= '0;
            out_total <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                shift <= in_data;
                acc_q <= in_acc;
                part  <= '0;
                step  <= '0;
            end
            if (state == COUNT) begin
                part  <= cnt_nxt;
                shift <= shift >> CW;
                step  <= step + 1'b1;
            end
            if (last) out_cnt <= cnt_nxt;
            if (last && acc_q) begin
                out_total <= sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
                out_ovf   <= sum[AW] | (out_ovf & ~clr);
            end else if (clr) begin
                out_total <= '0;
                out_ovf   <= 1'b0;
            end
        end
    end
endmodule
